// File: rtl/data_ram_slave_if.sv
// MEM-stage data memory bus: request from the pipeline, response and stall
// request back from the memory responder.
interface data_ram_slave_if;
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        stallreq_o;

    modport master (
        output ce, we, sel, addr, data_i,
        input  data_o, ack_o, stallreq_o
    );

    modport slave (
        input  ce, we, sel, addr, data_i,
        output data_o, ack_o, stallreq_o
    );
endinterface

// File: rtl/data_ram_slave.sv
// Wait-state data memory for the MEM stage. Each access occupies
// LATENCY+2 cycles: request, LATENCY wait cycles, then a one-cycle ack.
// The pipeline is stalled from the request cycle until the ack cycle.
module data_ram_slave #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    data_ram_slave_if.slave  bus
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state, state_nx;
    logic [3:0]              cnt, cnt_nx;

    logic                    req_we;
    logic [3:0]              req_sel;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [31:0]             req_data;
    logic                    latch_en;

    logic                    do_access;
    logic                    acc_we;
    logic [3:0]              acc_sel;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_data;

    logic [31:0]             data_q;
    logic                    ack_q;

    logic [31:0]             mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0]   in_idx;
    logic                    unused_addr_bits;

    // Word index from the byte address; byte offset and high bits wrap away.
    assign in_idx           = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

    // Next state, wait counter and selection of the access operands.
    // With zero latency the access happens at the request edge, so the live
    // inputs are used instead of the latched copy.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        latch_en  = 1'b0;
        do_access = 1'b0;
        acc_we    = req_we;
        acc_sel   = req_sel;
        acc_idx   = req_idx;
        acc_data  = req_data;
        case (state)
            IDLE: begin
                if (bus.ce) begin
                    latch_en = 1'b1;
                    if (LATENCY == 0) begin
                        do_access = 1'b1;
                        acc_we    = bus.we;
                        acc_sel   = bus.sel;
                        acc_idx   = in_idx;
                        acc_data  = bus.data_i;
                        state_nx  = DONE;
                    end else begin
                        cnt_nx   = CNT_LOAD;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counter, request latch and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req_we   <= 1'b0;
            req_sel  <= '0;
            req_idx  <= '0;
            req_data <= '0;
            data_q   <= '0;
            ack_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ack_q <= do_access;
            if (latch_en) begin
                req_we   <= bus.we;
                req_sel  <= bus.sel;
                req_idx  <= in_idx;
                req_data <= bus.data_i;
            end
            if (do_access && !acc_we) begin
                data_q <= mem[acc_idx];
            end
        end
    end

    // Byte-lane write into the array; contents survive reset, and a write
    // is suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && do_access && acc_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.data_o     = data_q;
    assign bus.ack_o      = ack_q;
    assign bus.stallreq_o = ((state == IDLE) && bus.ce) || (state == BUSY);

endmodule

// File: doc/data_ram_slave.md
# data_ram_slave

Wait-state data-memory responder for the MEM stage of the five-stage pipeline. It accepts the stage's chip-enable, write-enable, byte-select, address and write-data signals and performs the word access after a programmable number of wait cycles. While the access is in flight it raises a stall request toward the pipeline controller, then returns read data with a one-cycle acknowledge. Storage is an internal word array; the block replaces the zero-wait data RAM when slower memory timing must be modelled.

## Interface
- ADDR_WIDTH, 10: word-address bits; array depth is 2^ADDR_WIDTH words.
- LATENCY, 2: extra wait cycles per access; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: asynchronous, active-low.
- ce  in  1  request enable from the MEM stage.
- we  in  1  1 = write, 0 = read.
- sel  in  4  byte-lane enables; sel[3] selects bits 31:24, sel[0] selects bits 7:0.
- addr  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word.
- data_i  in  32  write data.
- data_o  out  32  registered read data.
- ack_o  out  1  registered; high for exactly one cycle when the access completes.
- stallreq_o  out  1  combinational stall request to the controller.

## Operation
- Three-state FSM: IDLE, BUSY, DONE. Counter cnt is 4 bits wide.
- IDLE:
  - On ce=1, latch we, sel, word index and data_i.
  - If LATENCY=0, perform the access at this edge and go to DONE.
  - Otherwise load cnt=LATENCY-1 and go to BUSY.
  - On ce=0, stay in IDLE.
- BUSY:
  - If cnt≠0, decrement cnt.
  - If cnt=0, perform the access using the latched values and go to DONE.
  - The ce, addr and data inputs are ignored in BUSY; dropping ce mid-access still completes the latched request.
- DONE:
  - ack_o=1; the next state is unconditionally IDLE.
  - ce is ignored in DONE: it is still the completing request, and the pipeline advances at the end of this cycle.
- Access rules:
  - Write: update only the byte lanes with sel bit = 1. sel=0000 writes nothing but still completes with ack. data_o is unchanged by writes.
  - Read: data_o receives the full addressed word. sel is ignored, because the MEM stage performs the byte and halfword extraction.
- Address handling:
  - addr[1:0] is ignored (no alignment check).
  - Address bits above ADDR_WIDTH+1 are ignored, so accesses wrap modulo the array depth.
- stallreq_o = (state=IDLE & ce) | (state=BUSY). It is 0 in DONE.
- Reset (rst=0, at any time, including mid-access):
  - state goes to IDLE, cnt=0, data_o=0, ack_o=0.
  - stallreq_o follows its equation, so it reads 0 while ce=0.
  - A pending write that has not yet been performed is discarded.
  - Array contents are not reset.

## Timing
- A request issued in cycle T is held by the requester while stallreq_o=1.
- Stall cycles per access = LATENCY+1, in cycles T..T+LATENCY.
- DONE falls in cycle T+LATENCY+1: ack_o=1, and data_o is valid in the same cycle.
- Total occupancy per access is LATENCY+2 cycles.
- Back-to-back requests: a new ce seen in IDLE in cycle T+LATENCY+2 starts the next access. There is no dead cycle beyond DONE.
- The write takes effect at the clock edge that ends cycle T+LATENCY. A read issued immediately afterwards returns the new data.
- The array is read and written only on clk edges; there are no combinational read paths to data_o.

## Test plan
- Reset with LATENCY=2, then read: rst=0 for 3 cycles gives data_o=0, ack_o=0, stallreq_o=0 with ce=0. Release reset and read addr 0x0 → stallreq_o high for 3 cycles, ack_o high in the 4th, data_o returns the array init value.
- Full-word write/read with LATENCY=2:
  - Write 0x12345678 to 0x40 with sel=1111 → stallreq_o high 3 cycles, then ack 1 cycle.
  - Read 0x40 → data_o=0x12345678 in the ack cycle.
- Byte lanes:
  - Preload 0xFFFFFFFF at 0x44, then write 0x00AB00CD with sel=0101 → a read of 0x44 returns 0xFFABFFCD.
  - sel=0000 write → word unchanged, ack still issued.
- LATENCY=0 back-to-back: write 0xA5A5A5A5 to 0x8, then immediately read 0x8 → each access has stall 1 cycle and ack in the 2nd cycle; the read returns 0xA5A5A5A5; the second stallreq begins the cycle after the first ack.
- Wrap and ignored bits: write 0xDEADBEEF to 0x0, then read 0x1003 with ADDR_WIDTH=10 → data_o=0xDEADBEEF.
- Reset mid-write with LATENCY=4: assert rst=0 during the 2nd BUSY cycle of a write of 0x11111111 to 0x20, holding the old value 0x22222222 → outputs go to their reset values immediately, and a later read of 0x20 returns 0x22222222.
